// File: rtl/image_downscale_if.sv
// rtl/image_downscale_if.sv - pixel stream bundle between video source, image_downscale and NPU buffer
interface image_downscale_if #(
    parameter int DATA_W = 16
);
    logic              img_vs;
    logic              img_data_valid;
    logic [DATA_W-1:0] img_data;
    logic [1:0]        scale_mode;
    logic              img_data_valid_out;
    logic [DATA_W-1:0] img_data_out;
    logic              frame_done;

    modport slave (
        input  img_vs, img_data_valid, img_data, scale_mode,
        output img_data_valid_out, img_data_out, frame_done
    );

    modport master (
        output img_vs, img_data_valid, img_data, scale_mode,
        input  img_data_valid_out, img_data_out, frame_done
    );
endinterface

// File: rtl/image_downscale.sv
// rtl/image_downscale.sv - frame downscaler: bypass, 2:1, 4:1 decimation and 2x2 RGB565 box average
module image_downscale #(
    parameter int DATA_W  = 16,
    parameter int COL_NUM = 1280,
    parameter int ROW_NUM = 720,
    parameter int CNT_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    image_downscale_if.slave bus
);
    localparam int LB_DEPTH = COL_NUM / 2;
    localparam int LB_AW    = $clog2(LB_DEPTH);

    logic              vs_d1;
    logic              vs_pos;
    logic              frame_live;
    logic              accept;
    logic [CNT_W-1:0]  col_cnt;
    logic [CNT_W-1:0]  row_cnt;
    logic [1:0]        mode_q;
    logic [1:0]        mode_eff;
    logic              col_last;
    logic              row_last;
    logic              fwd;
    logic [DATA_W-1:0] avg_pix;

    // A pixel arriving with the vs edge belongs to no frame; after reset nothing
    // is accepted until a frame start has been seen.
    assign vs_pos   = bus.img_vs & ~vs_d1;
    assign accept   = bus.img_data_valid & frame_live & ~vs_pos;
    assign col_last = (col_cnt == CNT_W'(COL_NUM - 1));
    assign row_last = (row_cnt == CNT_W'(ROW_NUM - 1));

    // Frame-start edge detect, per-frame mode latch and arming after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d1      <= 1'b0;
            frame_live <= 1'b0;
            mode_q     <= 2'd0;
        end else begin
            vs_d1 <= bus.img_vs;
            if (vs_pos) begin
                frame_live <= 1'b1;
                mode_q     <= bus.scale_mode;
            end
        end
    end

    // Pixel position within the frame; an overlong frame wraps back to (0,0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (vs_pos) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_cnt <= '0;
                row_cnt <= row_last ? '0 : row_cnt + CNT_W'(1);
            end else begin
                col_cnt <= col_cnt + CNT_W'(1);
            end
        end
    end

    // Decide whether the current pixel position produces an output pixel
    always_comb begin
        mode_eff = mode_q;
        fwd      = 1'b0;
        if (mode_q == 2'd3 && DATA_W != 16) begin
            mode_eff = 2'd1;
        end
        case (mode_eff)
            2'd0:    fwd = 1'b1;
            2'd1:    fwd = ~col_cnt[0] & ~row_cnt[0];
            2'd2:    fwd = (col_cnt[1:0] == 2'd0) && (row_cnt[1:0] == 2'd0);
            default: fwd = col_cnt[0] & row_cnt[0];
        endcase
    end

    generate
        if (DATA_W == 16) begin : g_avg
            logic [15:0]      hold_q;
            logic [18:0]      lb_rd;
            logic [18:0]      line_buf [LB_DEPTH];
            logic [LB_AW-1:0] lb_addr;
            logic [5:0]       hs_r;
            logic [6:0]       hs_g;
            logic [5:0]       hs_b;
            logic [6:0]       sum_r;
            logic [7:0]       sum_g;
            logic [6:0]       sum_b;

            assign lb_addr = col_cnt[LB_AW:1];
            assign hs_r    = {1'b0, hold_q[15:11]} + {1'b0, bus.img_data[15:11]};
            assign hs_g    = {1'b0, hold_q[10:5]}  + {1'b0, bus.img_data[10:5]};
            assign hs_b    = {1'b0, hold_q[4:0]}   + {1'b0, bus.img_data[4:0]};
            assign sum_r   = {1'b0, lb_rd[18:13]} + {1'b0, hs_r};
            assign sum_g   = {1'b0, lb_rd[12:6]}  + {1'b0, hs_g};
            assign sum_b   = {1'b0, lb_rd[5:0]}   + {1'b0, hs_b};
            assign avg_pix = {sum_r[6:2], sum_g[7:2], sum_b[6:2]};

            // Even column: hold the left pixel and prefetch the upper-row pair sum,
            // so the odd-column pixel can finish the block in the same cycle
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_q <= '0;
                    lb_rd  <= '0;
                end else if (vs_pos) begin
                    hold_q <= '0;
                end else if (accept && !col_cnt[0]) begin
                    hold_q <= bus.img_data;
                    lb_rd  <= line_buf[lb_addr];
                end
            end

            // Even row, odd column: store the horizontal pair sum for the row below
            always_ff @(posedge clk) begin
                if (accept && mode_q == 2'd3 && col_cnt[0] && !row_cnt[0]) begin
                    line_buf[lb_addr] <= {hs_r, hs_g, hs_b};
                end
            end
        end else begin : g_no_avg
            assign avg_pix = '0;
        end
    endgenerate

    // Registered outputs: strobe one cycle after the qualifying pixel, data holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.img_data_valid_out <= 1'b0;
            bus.img_data_out       <= '0;
            bus.frame_done         <= 1'b0;
        end else begin
            bus.img_data_valid_out <= accept & fwd;
            bus.frame_done         <= accept & col_last & row_last;
            if (accept && fwd) begin
                bus.img_data_out <= (mode_eff == 2'd3) ? avg_pix : bus.img_data;
            end
        end
    end
endmodule

// File: tb/tb_image_downscale.sv
// tb/tb_image_downscale.sv - directed self-checking bench for image_downscale on an 8x4 frame
module tb_image_downscale;
    localparam int DW = 16;
    localparam int CN = 8;
    localparam int RN = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    image_downscale_if #(.DATA_W(DW)) bus ();

    image_downscale #(
        .DATA_W (DW),
        .COL_NUM(CN),
        .ROW_NUM(RN),
        .CNT_W  (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          out_cnt;
    int          done_cnt;
    logic [15:0] frame [RN][CN];
    logic [15:0] exp_last;
    logic [15:0] first_avg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic exp_v,
                        input logic [15:0] exp_d, input logic exp_done, input string tag);
        bus.img_data_valid = v;
        bus.img_data       = d;
        tick();
        if (exp_v) exp_last = exp_d;
        chk({tag, " valid"}, 32'(bus.img_data_valid_out), 32'(exp_v));
        chk({tag, " data"},  32'(bus.img_data_out),       32'(exp_last));
        chk({tag, " done"},  32'(bus.frame_done),         32'(exp_done));
        if (bus.img_data_valid_out === 1'b1) out_cnt++;
        if (bus.frame_done === 1'b1) done_cnt++;
        bus.img_data_valid = 1'b0;
    endtask

    function automatic logic [15:0] avg4(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic [15:0] d);
        int r, g, bl;
        r  = int'(a[15:11]) + int'(b[15:11]) + int'(c[15:11]) + int'(d[15:11]);
        g  = int'(a[10:5])  + int'(b[10:5])  + int'(c[10:5])  + int'(d[10:5]);
        bl = int'(a[4:0])   + int'(b[4:0])   + int'(c[4:0])   + int'(d[4:0]);
        return {5'(r >> 2), 6'(g >> 2), 5'(bl >> 2)};
    endfunction

    task automatic start_frame(input logic [1:0] mode, input logic v, input logic [15:0] d);
        bus.img_vs     = 1'b1;
        bus.scale_mode = mode;
        step(v, d, 1'b0, 16'h0, 1'b0, "vs");
        bus.img_vs = 1'b0;
    endtask

    task automatic run_frame(input int mode, input bit gaps, input int chg_at);
        logic        ev;
        logic [15:0] ed;
        out_cnt  = 0;
        done_cnt = 0;
        for (int r = 0; r < RN; r++) begin
            for (int c = 0; c < CN; c++) begin
                if (gaps) begin
                    while ($urandom_range(0, 9) < 3) step(1'b0, 16'hDEAD, 1'b0, 16'h0, 1'b0, "gap");
                end
                if (r * CN + c == chg_at) bus.scale_mode = 2'd2;
                ev = 1'b0;
                ed = 16'h0;
                case (mode)
                    0: ev = 1'b1;
                    1: ev = (r % 2 == 0) && (c % 2 == 0);
                    2: ev = (r % 4 == 0) && (c % 4 == 0);
                    default: begin
                        if ((r % 2 == 1) && (c % 2 == 1)) begin
                            ev = 1'b1;
                            ed = avg4(frame[r-1][c-1], frame[r-1][c], frame[r][c-1], frame[r][c]);
                        end
                    end
                endcase
                if (mode != 3) ed = frame[r][c];
                step(1'b1, frame[r][c], ev, ed, (r == RN - 1) && (c == CN - 1),
                     $sformatf("m%0d r%0d c%0d", mode, r, c));
                if (mode == 3 && r == 1 && c == 1) first_avg = bus.img_data_out;
            end
        end
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < RN; r++)
            for (int c = 0; c < CN; c++)
                frame[r][c] = 16'(r * CN + c);
    endtask

    task automatic fill_random();
        for (int r = 0; r < RN; r++)
            for (int c = 0; c < CN; c++)
                frame[r][c] = 16'($urandom);
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.img_vs         = 1'b0;
        bus.img_data_valid = 1'b0;
        bus.img_data       = '0;
        bus.scale_mode     = 2'd0;
        exp_last           = 16'h0;
        first_avg          = 16'h0;
        tick();
        tick();
        chk("reset valid", 32'(bus.img_data_valid_out), 32'd0);
        chk("reset data",  32'(bus.img_data_out),       32'd0);
        chk("reset done",  32'(bus.frame_done),         32'd0);
        rst_n = 1'b1;
        tick();

        fill_ramp();
        start_frame(2'd1, 1'b0, 16'h0);
        run_frame(1, 1'b0, -1);
        chk("mode1 count", 32'(out_cnt), 32'd8);
        chk("mode1 done",  32'(done_cnt), 32'd1);

        start_frame(2'd2, 1'b0, 16'h0);
        run_frame(2, 1'b0, -1);
        chk("mode2 count", 32'(out_cnt), 32'd2);

        start_frame(2'd0, 1'b0, 16'h0);
        run_frame(0, 1'b0, -1);
        chk("mode0 count", 32'(out_cnt), 32'd32);

        fill_random();
        frame[0][0] = 16'hF800;
        frame[0][1] = 16'hF800;
        frame[1][0] = 16'h0000;
        frame[1][1] = 16'h07E0;
        start_frame(2'd3, 1'b0, 16'h0);
        run_frame(3, 1'b0, -1);
        chk("avg block0",  32'(first_avg), 32'h79E0);
        chk("mode3 count", 32'(out_cnt), 32'd8);

        fill_random();
        start_frame(2'd3, 1'b0, 16'h0);
        run_frame(3, 1'b1, -1);
        chk("mode3 gap count", 32'(out_cnt), 32'd8);
        chk("mode3 gap done",  32'(done_cnt), 32'd1);

        fill_ramp();
        start_frame(2'd1, 1'b0, 16'h0);
        run_frame(1, 1'b0, 12);
        chk("midchange count", 32'(out_cnt), 32'd8);
        start_frame(2'd2, 1'b1, 16'hABCD);
        run_frame(2, 1'b0, -1);
        chk("vs drop count", 32'(out_cnt), 32'd2);

        start_frame(2'd0, 1'b0, 16'h0);
        for (int c = 0; c < 5; c++) step(1'b1, frame[0][c], 1'b1, frame[0][c], 1'b0, "prereset");
        rst_n = 1'b0;
        #2;
        chk("async rst valid", 32'(bus.img_data_valid_out), 32'd0);
        chk("async rst data",  32'(bus.img_data_out),       32'd0);
        chk("async rst done",  32'(bus.frame_done),         32'd0);
        exp_last = 16'h0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) step(1'b1, 16'h1234, 1'b0, 16'h0, 1'b0, "unarmed");
        start_frame(2'd1, 1'b0, 16'h0);
        run_frame(1, 1'b0, -1);
        chk("post reset count", 32'(out_cnt), 32'd8);
        chk("post reset done",  32'(done_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
